// File: rtl/dmem_pkg.sv
// Shared definitions for the block-granular data memory: geometry, FSM states and
// byte-lane placement within a block.
package dmem_pkg;

    localparam int unsigned BLOCK_W         = 32;
    localparam int unsigned BLOCK_ADDR_W    = 6;
    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned BYTES_PER_BLOCK = BLOCK_W / BYTE_W;
    localparam int unsigned MEM_BYTES       = BYTES_PER_BLOCK << BLOCK_ADDR_W;

    // Byte k of a block lives at bits [8k+7:8k], matching the cache offset order.
    localparam int unsigned LANE_STRIDE = BYTE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned lane_lsb(input int unsigned k);
        return LANE_STRIDE * k;
    endfunction

endpackage

// File: rtl/dmem_latency_counter.sv
// Down-counter that times one memory access: loads ACCESS_CYCLES-1 on start,
// decrements on request and reports when it has reached zero.
module dmem_latency_counter
    import dmem_pkg::*;
#(
    parameter int unsigned ACCESS_CYCLES = 5,
    localparam int unsigned CNT_W = $clog2(ACCESS_CYCLES) + 1
) (
    input  logic CLK,
    input  logic RESET,
    input  logic load,
    input  logic dec,
    output logic zero
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= CNT_W'(ACCESS_CYCLES - 1);
        end else if (dec) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/data_memory_block.sv
// Responder end of the cache-to-memory interface: 64 blocks of 4 bytes served with a
// fixed multi-cycle latency, stalling the initiator through mem_busywait.
module data_memory_block
    import dmem_pkg::*;
#(
    parameter int unsigned ACCESS_CYCLES = 5,
    parameter int unsigned BLOCK_ADDR_W  = dmem_pkg::BLOCK_ADDR_W,
    parameter int unsigned BLOCK_W       = dmem_pkg::BLOCK_W
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [BLOCK_ADDR_W-1:0] mem_block_address,
    input  logic [BLOCK_W-1:0]      mem_WriteData,
    output logic [BLOCK_W-1:0]      mem_ReadData,
    output logic                    mem_busywait
);

    localparam int unsigned BYTES = BLOCK_W / BYTE_W;
    localparam int unsigned DEPTH = BYTES << BLOCK_ADDR_W;

    state_t                  state_q;
    logic [BLOCK_ADDR_W-1:0] addr_q;
    logic [BLOCK_W-1:0]      wdata_q;
    logic                    write_q;
    logic [BYTE_W-1:0]       mem [DEPTH];

    logic               request;
    logic               start;
    logic               cnt_dec;
    logic               cnt_zero;
    logic               finish;
    logic [BLOCK_W-1:0] block_rd;

    assign request = mem_read | mem_write;
    assign start   = (state_q == IDLE) && request;
    assign cnt_dec = (state_q == BUSY) && !cnt_zero;
    assign finish  = (state_q == BUSY) && cnt_zero;

    // Held low while RESET is asserted so an aborted access never looks pending.
    assign mem_busywait = !RESET && (start || (state_q == BUSY));

    dmem_latency_counter #(
        .ACCESS_CYCLES(ACCESS_CYCLES)
    ) u_latency (
        .CLK  (CLK),
        .RESET(RESET),
        .load (start),
        .dec  (cnt_dec),
        .zero (cnt_zero)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (request) begin
                        addr_q  <= mem_block_address;
                        wdata_q <= mem_WriteData;
                        write_q <= mem_write;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_zero) begin
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        block_rd = '0;
        for (int k = 0; k < BYTES; k++) begin
            block_rd[lane_lsb(k) +: BYTE_W] = mem[int'(addr_q) * BYTES + k];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (finish && write_q) begin
            for (int k = 0; k < BYTES; k++) begin
                mem[int'(addr_q) * BYTES + k] <= wdata_q[lane_lsb(k) +: BYTE_W];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            mem_ReadData <= '0;
        end else if (finish && !write_q) begin
            mem_ReadData <= block_rd;
        end
    end

endmodule

// File: doc/data_memory_block.md
Name: data_memory_block

Overview:
- Block-granular data memory: the responder end of the cache-to-memory interface.
- Serves 32-bit block reads and write-backs issued by the data cache miss controller.
- Holds 256 bytes as 64 blocks of 4 bytes, with a fixed multi-cycle access latency.
- Stalls the initiator through mem_busywait until each access completes.

Parameters:
ACCESS_CYCLES, 5, clock edges from request sample to completion (must be >= 1)
BLOCK_ADDR_W, 6, block address width (64 blocks)
BLOCK_W, 32, block data width (4 bytes)

Ports:
CLK  input  1  clock, all state changes on posedge
RESET  input  1  synchronous, active-high
mem_read  input  1  block read request, held by initiator until busywait drops
mem_write  input  1  block write request, held by initiator until busywait drops
mem_block_address  input  6  block index {tag,index} from cache
mem_WriteData  input  32  block to store; byte k at bits [8k+7:8k]
mem_ReadData  output  32  block read result, registered
mem_busywait  output  1  high while a request is pending or in service

Behaviour:
- Interface decision: reset RESET, synchronous, active-high; clock CLK.
- Storage: 256 x 8-bit array. Block b occupies bytes 4b..4b+3. Byte 4b+k maps to bits [8k+7:8k], matching cache offset order.
- States: IDLE, BUSY, DONE. Counter width is clog2(ACCESS_CYCLES)+1.
- Reset at posedge with RESET=1:
  - state goes to IDLE, counter to 0, mem_ReadData to 0;
  - all 256 bytes are cleared to 0;
  - an in-flight access is aborted and its pending write is not committed.
- mem_busywait is combinational: (IDLE && (mem_read||mem_write)) || BUSY. It is 0 in DONE and 0 during reset.
- IDLE: at posedge with mem_read or mem_write high:
  - latch address, latch write data, latch op (write wins if both are high);
  - load counter = ACCESS_CYCLES-1;
  - go to BUSY.
- BUSY: each posedge with counter != 0 decrements the counter. At the posedge with counter == 0:
  - a write commits all 4 bytes of the latched data;
  - a read registers the addressed block into mem_ReadData;
  - go to DONE.
- Latency: with the request sampled at edge N, DONE is entered at edge N+ACCESS_CYCLES. ACCESS_CYCLES=1 gives DONE at edge N+1.
- DONE: lasts exactly one cycle. mem_ReadData is valid. Request inputs are ignored. Next posedge goes unconditionally to IDLE, with no re-sample at that edge.
- Back-to-back requests: a request raised in the cycle after DONE raises busywait immediately and is sampled at the next posedge. This supports the write-back-then-read sequence.
- Inputs changing during BUSY have no effect because latched values are used.
- mem_ReadData holds its last value through writes and IDLE. It changes only on read completion or reset.
- A write never updates mem_ReadData.
- Out-of-range address: none possible (6 bits cover all 64 blocks).

Decomposition:
- Shared package (dmem_pkg):
  - state encoding constants IDLE=2'd0, BUSY=2'd1, DONE=2'd2;
  - BLOCK_W and BLOCK_ADDR_W;
  - byte-lane ordering constant.
- Natural sub-module: dmem_latency_counter. It loads ACCESS_CYCLES-1 on start, decrements, and flags zero. The top-level handles the FSM, storage and data path.

Test Plan:
- Reset then read block 6'd5 -> busywait high for 5 cycles after the sample edge, DONE at sample+5, mem_ReadData=32'h00000000.
- Write block 6'd10 with 32'hDEADBEEF, then read block 6'd10 -> second access returns 32'hDEADBEEF; byte 40 holds 8'hEF and byte 43 holds 8'hDE.
- Write-back to block 6'd3 (32'h11223344) immediately followed by read of block 6'd35 -> busywait re-asserts in the cycle after DONE; read returns the prior contents of block 35; block 3 now holds 32'h11223344.
- mem_read and mem_write both high, address 6'd7, data 32'hA5A5A5A5 -> treated as write; subsequent read of block 7 returns 32'hA5A5A5A5; mem_ReadData unchanged by the write.
- RESET asserted 2 cycles into a write of 32'hCAFEF00D to block 6'd20 -> busywait low the cycle after reset; read of block 20 returns 32'h00000000.
- ACCESS_CYCLES=1 build, read after write of 32'h01020304 to block 6'd63 -> each access completes in one edge; read returns 32'h01020304.
